param_alu_sequencer: RTL and testbench
======================================

Name: param_alu_sequencer

Overview:
- Parametrised successor to the 8-bit ALU control unit: one 5-phase sequencer driving the 18-bit control word c for AND, OR, XOR, ADD, SUB, radix-4 Booth MUL and non-restoring DIV.
- Iteration count is generated internally from WIDTH; no external countN flag.
- Adds a start/busy/done handshake, latching of op at start, and detection of the illegal opcode.
- Sits between the ALU top level and the datapath registers A, Q, M and the counter.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 4.
- CNT_W, 4, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110 DIV, 111 illegal
- q1  in  1  Booth multiplier bit Q[1]
- q0  in  1  Booth multiplier bit Q[0]
- r  in  1  Booth appended bit
- a_msb  in  1  sign of partial remainder A
- c  out  18  datapath control word; combinational from state, phase, latched op and status inputs
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle registered completion pulse
- err  out  1  one-cycle pulse, coincident with done, for illegal op
- count  out  CNT_W  current iteration index

Behaviour:
- Reset: when reset=1 at a clock edge, the block goes to IDLE with phase=0, count=0, op_q=0, done=0, err=0. This holds from any state, including mid-operation. With state IDLE, c=0 and busy=0.
- States: IDLE, LOAD, ITER, FINISH. A phase counter runs 0..4 inside LOAD and ITER, and 0..1 inside FINISH. It clears on every state change.
- IDLE with start=1 and op!=111: op_q<=op, count<=0, go to LOAD.
- IDLE with start=1 and op=111: stay in IDLE; done=1 and err=1 next cycle; c stays 0.
- start while busy: ignored; op_q does not change.
- LOAD at phase 4: MUL/DIV go to ITER, all other ops go to FINISH.
- ITER: at phase 4 count increments. Define last = (count == NI-1), with NI = WIDTH/2 for MUL and WIDTH for DIV. At phase 4 with last=1, go to FINISH instead of incrementing.
- FINISH at phase 1: go to IDLE; done<=1 registered, so done is high in the first IDLE cycle.
- start is accepted in the same cycle done is high.
- Control word in LOAD:
  - phase 0: c0.
  - phase 1: c1.
  - phase 2: c2 if op_q<=100; c15 if SUB; c10 if DIV.
  - phase 3: c16 if op_q<=010; c11 if DIV.
- Control word in ITER:
  - phase 0: c3 if MUL and (q0^r); c4 if MUL and q1 and (q0^r); c12 if DIV.
  - phase 1: c5 if MUL; c13 if DIV and a_msb; c14 if DIV and !a_msb.
  - phase 2: c6 if !last.
  - phase 3: c17 if DIV.
- Control word in FINISH:
  - phase 0: c7; c5 if MUL.
  - phase 1: c8 if not DIV; c9 if DIV.
- All c bits not listed above are 0.
- Latency: start is sampled in cycle 0 and done is high in cycle T.
  - Logic, ADD and SUB: T=8.
  - MUL: T = 8 + 5*(WIDTH/2).
  - DIV: T = 8 + 5*WIDTH.
- count holds its final value until the next LOAD.

Optional Feature:
- Macro: PARAM_ALU_SEQUENCER_ABORT_EN.
- When defined, the block adds input abort and output aborted.
  - abort=1 while busy: next cycle the state is IDLE, c=0, and aborted pulses for one cycle. done does not pulse.
  - abort in IDLE is ignored.
  - abort and start together in IDLE: start is accepted.
- When undefined, neither port exists and behaviour is as above.

Test Plan:
- WIDTH=8, op=011 ADD, start pulse in cycle 0 -> c0,c1,c2 in cycles 1-3; no c16 in cycle 4; c7 in cycle 6; c8 in cycle 7; done=1 in cycle 8 only; busy high in cycles 1-7.
- WIDTH=8, op=101 MUL, q1q0r=110 every iteration -> c3 and c4 asserted at ITER phase 0 in each of 4 iterations; c6 asserted 3 times; done in cycle 28; count=3 at FINISH.
- WIDTH=16, op=110 DIV, a_msb alternating 1/0 -> 16 iterations with c13 and c14 alternating; c17 every iteration; c9 in FINISH; done in cycle 88.
- op=111, start=1 -> done=1 and err=1 in cycle 1; busy=0 throughout; c=0.
- DIV started, reset=1 in cycle 20 -> cycle 21: IDLE, c=0, busy=0, count=0, no done; a new start with op=000 completes with done in 8 cycles.
- With the ABORT macro defined: MUL running, abort=1 at ITER phase 2 -> next cycle aborted=1, c=0, busy=0, done stays 0; a start held high during busy is ignored.

Source files
------------

// File: rtl/param_alu_sequencer.sv
// param_alu_sequencer
//   Five-phase control sequencer for a parametrised ALU datapath (A, Q, M
//   registers plus iteration counter). Drives the 18-bit control word for
//   AND, OR, XOR, ADD, SUB, radix-4 Booth MUL and non-restoring DIV.
//   The iteration count comes from WIDTH: WIDTH/2 steps for MUL, WIDTH
//   steps for DIV.
//
// Parameters
//   WIDTH  operand width, even and >= 4
//   CNT_W  iteration counter width, 2**CNT_W > WIDTH
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   start    request, sampled only while idle
//   op       opcode (000 AND .. 110 DIV, 111 illegal)
//   q1, q0   Booth multiplier bits Q[1], Q[0]
//   r        Booth appended bit
//   a_msb    sign of partial remainder A
//   c        datapath control word (combinational)
//   busy     high whenever not idle
//   done     one-cycle registered completion pulse
//   err      one-cycle pulse alongside done for an illegal opcode
//   count    current iteration index
//
// Optional build macro PARAM_ALU_SEQUENCER_ABORT_EN adds:
//   abort    cancel the running operation (ignored while idle)
//   aborted  one-cycle pulse after an accepted abort; done does not pulse

module param_alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             q1,
  input  logic             q0,
  input  logic             r,
  input  logic             a_msb,
`ifdef PARAM_ALU_SEQUENCER_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [17:0]      c,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, FINISH} state_t;

  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  // Index of the final iteration for each iterative operation
  localparam logic [CNT_W-1:0] LAST_MUL = CNT_W'(WIDTH / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_DIV = CNT_W'(WIDTH - 1);

  state_t     state;
  logic [2:0] phase;
  logic [2:0] op_q;
  logic       is_mul;
  logic       is_div;
  logic       last;
  logic       abort_hit;

  assign is_mul = (op_q == OP_MUL);
  assign is_div = (op_q == OP_DIV);
  assign last   = (is_mul && (count == LAST_MUL)) || (is_div && (count == LAST_DIV));
  assign busy   = (state != IDLE);

`ifdef PARAM_ALU_SEQUENCER_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      phase <= '0;
      count <= '0;
      op_q  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef PARAM_ALU_SEQUENCER_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
`ifdef PARAM_ALU_SEQUENCER_ABORT_EN
      aborted <= abort_hit;
`endif
      if (abort_hit) begin
        // Abort overrides every state, including the FINISH step that would
        // otherwise raise done; count is left as it was.
        state <= IDLE;
        phase <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (op == OP_ILL) begin
                done <= 1'b1;
                err  <= 1'b1;
              end else begin
                op_q  <= op;
                count <= '0;
                phase <= '0;
                state <= LOAD;
              end
            end
          end
          LOAD: begin
            if (phase == 3'd4) begin
              phase <= '0;
              state <= (is_mul || is_div) ? ITER : FINISH;
            end else begin
              phase <= phase + 3'd1;
            end
          end
          ITER: begin
            if (phase == 3'd4) begin
              phase <= '0;
              if (last) state <= FINISH;
              else      count <= count + 1'b1;
            end else begin
              phase <= phase + 3'd1;
            end
          end
          FINISH: begin
            if (phase == 3'd1) begin
              phase <= '0;
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              phase <= phase + 3'd1;
            end
          end
          default: begin
            state <= IDLE;
            phase <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    c = '0;
    case (state)
      LOAD: begin
        case (phase)
          3'd0: c[0] = 1'b1;
          3'd1: c[1] = 1'b1;
          3'd2: begin
            c[2]  = (op_q <= OP_SUB);
            c[15] = (op_q == OP_SUB);
            c[10] = is_div;
          end
          3'd3: begin
            c[16] = (op_q <= OP_XOR);
            c[11] = is_div;
          end
          default: ;
        endcase
      end
      ITER: begin
        case (phase)
          3'd0: begin
            c[3]  = is_mul && (q0 ^ r);
            c[4]  = is_mul && q1 && (q0 ^ r);
            c[12] = is_div;
          end
          3'd1: begin
            c[5]  = is_mul;
            c[13] = is_div && a_msb;
            c[14] = is_div && !a_msb;
          end
          3'd2: c[6]  = !last;
          3'd3: c[17] = is_div;
          default: ;
        endcase
      end
      FINISH: begin
        case (phase)
          3'd0: begin
            c[7] = 1'b1;
            c[5] = is_mul;
          end
          3'd1: begin
            c[8] = !is_div;
            c[9] = is_div;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_param_alu_sequencer.sv
// Randomised scoreboard bench for param_alu_sequencer.
// The driver issues stimulus once per cycle (just after the rising edge) and
// keeps a transaction-level model: the start cycle and opcode of the running
// operation, plus a queue of expected done/err pulses. The monitor samples on
// the falling edge and derives the expected control word, busy and count from
// the elapsed cycle count of the running transaction.

module tb_param_alu_sequencer;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int N_CYC = 4000;
  localparam int DRAIN = 120;

  logic          clk;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic          q1, q0, r, a_msb;
  logic [17:0]   c;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] count;
`ifdef PARAM_ALU_SEQUENCER_ABORT_EN
  logic          abort;
  logic          aborted;
`endif

  param_alu_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .q1    (q1),
    .q0    (q0),
    .r     (r),
    .a_msb (a_msb),
`ifdef PARAM_ALU_SEQUENCER_ABORT_EN
    .abort   (abort),
    .aborted (aborted),
`endif
    .c     (c),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic err;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Transaction model
  bit   act;
  int   s_cyc;
  logic [2:0] m_op;
  int   m_n;
  int   last_count;
  bit   kill_pend;
  int   kill_count;
  int   ab_cyc;

  function automatic int nops(input logic [2:0] o);
    if (o == 3'd5) return W / 2;
    if (o == 3'd6) return W;
    return 0;
  endfunction

  // Expected control word t cycles after the start was sampled
  function automatic logic [17:0] exp_c(input int t, input logic [2:0] o, input int n,
                                        input logic iq1, input logic iq0,
                                        input logic ir, input logic iam);
    logic [17:0] v;
    int ph;
    int k;
    bit mul;
    bit dv;
    v   = '0;
    mul = (o == 3'd5);
    dv  = (o == 3'd6);
    if (t <= 5) begin
      ph = t - 1;
      if (ph == 0) v[0] = 1'b1;
      if (ph == 1) v[1] = 1'b1;
      if (ph == 2) begin
        if (o <= 3'd4) v[2]  = 1'b1;
        if (o == 3'd4) v[15] = 1'b1;
        if (dv)        v[10] = 1'b1;
      end
      if (ph == 3) begin
        if (o <= 3'd2) v[16] = 1'b1;
        if (dv)        v[11] = 1'b1;
      end
    end else if (t <= 5 + 5 * n) begin
      k  = (t - 6) / 5;
      ph = (t - 6) % 5;
      if (ph == 0) begin
        if (mul && (iq0 != ir))        v[3]  = 1'b1;
        if (mul && iq1 && (iq0 != ir)) v[4]  = 1'b1;
        if (dv)                        v[12] = 1'b1;
      end
      if (ph == 1) begin
        if (mul)        v[5]  = 1'b1;
        if (dv && iam)  v[13] = 1'b1;
        if (dv && !iam) v[14] = 1'b1;
      end
      if (ph == 2 && k != n - 1) v[6] = 1'b1;
      if (ph == 3 && dv) v[17] = 1'b1;
    end else begin
      ph = t - 6 - 5 * n;
      if (ph == 0) begin
        v[7] = 1'b1;
        if (mul) v[5] = 1'b1;
      end
      if (ph == 1) begin
        if (dv) v[9] = 1'b1;
        else    v[8] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic int exp_count(input int t, input int n);
    if (t <= 5) return 0;
    if (t <= 5 + 5 * n) return (t - 6) / 5;
    return (n > 0) ? n - 1 : 0;
  endfunction

  // Driver
  initial begin
    bit quiet;
    bit ab;
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    {q1, q0, r, a_msb} = '0;
`ifdef PARAM_ALU_SEQUENCER_ABORT_EN
    abort = 1'b0;
`endif
    act        = 1'b0;
    s_cyc      = 0;
    m_op       = '0;
    m_n        = 0;
    last_count = 0;
    kill_pend  = 1'b0;
    kill_count = 0;
    ab_cyc     = -1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N_CYC + DRAIN; i++) begin
      @(posedge clk);
      #1;
      quiet = (i >= N_CYC);
      if (kill_pend) begin
        sb.delete();
        act        = 1'b0;
        last_count = kill_count;
        kill_pend  = 1'b0;
      end
      if (act && cyc == s_cyc + 8 + 5 * m_n) begin
        act        = 1'b0;
        last_count = (m_n > 0) ? m_n - 1 : 0;
      end
      {q1, q0, r, a_msb} = 4'($urandom);
      op    = 3'($urandom);
      start = quiet ? 1'b0 : (act ? ($urandom % 3 == 0) : ($urandom % 2 == 0));
      reset = quiet ? 1'b0 : ($urandom % 300 == 0);
      ab    = quiet ? 1'b0 : ($urandom % 80 == 0);
`ifdef PARAM_ALU_SEQUENCER_ABORT_EN
      abort = ab;
`else
      ab = 1'b0;
`endif
      if (reset) begin
        kill_pend  = 1'b1;
        kill_count = 0;
      end else if (act && ab) begin
        kill_pend  = 1'b1;
        kill_count = exp_count(cyc - s_cyc, m_n);
        ab_cyc     = cyc + 1;
      end else if (!act && start) begin
        if (op == 3'b111) begin
          sb.push_back('{cyc + 1, 1'b1});
        end else begin
          act   = 1'b1;
          s_cyc = cyc;
          m_op  = op;
          m_n   = nops(op);
          sb.push_back('{cyc + 8 + 5 * m_n, 1'b0});
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected done pulses never seen, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor
  always @(negedge clk) begin
    int t;
    bit inwin;
    bit due;
    logic due_err;
    logic [17:0] ec;
    logic [CW-1:0] ecnt;
    t     = cyc - s_cyc;
    inwin = act && (t >= 1);
    ec    = inwin ? exp_c(t, m_op, m_n, q1, q0, r, a_msb) : '0;
    ecnt  = inwin ? CW'(exp_count(t, m_n)) : CW'(last_count);
    total++;
    if ({c, busy, count} !== {ec, inwin, ecnt}) begin
      bad++;
      $display("FAIL ctrl cyc=%0d t=%0d op=%0d got c=%h busy=%b count=%0d want c=%h busy=%b count=%0d",
               cyc, t, m_op, c, busy, count, ec, inwin, ecnt);
    end
    due     = (sb.size() > 0) && (sb[0].cyc == cyc);
    due_err = due ? sb[0].err : 1'b0;
    total++;
    if ({done, err} !== {due, due_err}) begin
      bad++;
      $display("FAIL done cyc=%0d got done=%b err=%b want done=%b err=%b",
               cyc, done, err, due, due_err);
    end
    if (due) void'(sb.pop_front());
`ifdef PARAM_ALU_SEQUENCER_ABORT_EN
    total++;
    if (aborted !== (cyc == ab_cyc)) begin
      bad++;
      $display("FAIL aborted cyc=%0d got %b want %b", cyc, aborted, (cyc == ab_cyc));
    end
`endif
  end

endmodule
